// File: rtl/mem_fu.sv
// Load/store functional unit on RS issue slot 2: one op at a time, fixed-latency
// access to a private byte-addressed data memory, one-cycle tagged completion.
module mem_fu #(
  parameter int MEM_BYTES   = 1024,
  parameter int MEM_LATENCY = 2,
  parameter int ROB_W       = 4,
  parameter int PREG_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [ROB_W-1:0]  issue_rob_num,
  input  logic [PREG_W-1:0] issue_rd,
  input  logic [31:0]       issue_rs1_val,
  input  logic [31:0]       issue_rs2_val,
  input  logic [31:0]       issue_imm,
  input  logic              issue_mem_read,
  input  logic              issue_mem_write,
  input  logic [2:0]        issue_funct3,
  output logic              fu_ready,
  output logic              complete_valid,
  output logic [ROB_W-1:0]  complete_rob_num,
  output logic [PREG_W-1:0] complete_rd,
  output logic              complete_reg_write,
  output logic [31:0]       complete_value,
  output logic              complete_exception
);

  localparam int         AW      = $clog2(MEM_BYTES);
  localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ROB_W-1:0]  robNum_q;
  logic [PREG_W-1:0] rd_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic              read_q;
  logic              write_q;
  logic [2:0]        funct3_q;

  logic [ROB_W-1:0]  complRob_q;
  logic [PREG_W-1:0] complRd_q;
  logic              complRegWrite_q;
  logic [31:0]       complValue_q;
  logic              complExc_q;

  logic [7:0] mem [MEM_BYTES];

  logic          accept;
  logic          accessFire;
  logic          sizeByte, sizeHalf, sizeWord;
  logic          loadLegal, storeLegal, misaligned, excFlag;
  logic          doLoad, doStore;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   loadValue;

  assign accept     = (state_q == IDLE) && issue_valid && !flush;
  assign accessFire = (state_q == ACCESS) && (cnt_q == LastCnt) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush takes priority over the access edge so an aborted store never lands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue_valid && !flush) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    fu_ready       = (state_q == IDLE);
    complete_valid = (state_q == RESP) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      robNum_q <= '0;
      rd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      funct3_q <= '0;
    end else if (accept) begin
      robNum_q <= issue_rob_num;
      rd_q     <= issue_rd;
      addr_q   <= AW'(issue_rs1_val + issue_imm);
      wdata_q  <= issue_rs2_val;
      read_q   <= issue_mem_read;
      write_q  <= issue_mem_write;
      funct3_q <= issue_funct3;
    end
  end

  always_comb begin
    sizeByte   = (funct3_q[1:0] == 2'b00);
    sizeHalf   = (funct3_q[1:0] == 2'b01);
    sizeWord   = (funct3_q[1:0] == 2'b10);
    loadLegal  = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                 (funct3_q == 3'b100) || (funct3_q == 3'b101);
    storeLegal = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
    misaligned = (sizeHalf && addr_q[0]) || (sizeWord && (addr_q[1:0] != 2'b00));
    excFlag    = (read_q && write_q) ||
                 (read_q && (!loadLegal || misaligned)) ||
                 (write_q && (!storeLegal || misaligned));
    doLoad     = read_q && !write_q && !excFlag;
    doStore    = write_q && !read_q && !excFlag;
  end

  // Byte lanes are little-endian and wrap within the memory.
  always_comb begin
    idx0 = addr_q;
    idx1 = addr_q + AW'(1);
    idx2 = addr_q + AW'(2);
    idx3 = addr_q + AW'(3);
    b0   = mem[idx0];
    b1   = mem[idx1];
    b2   = mem[idx2];
    b3   = mem[idx3];
    case (funct3_q)
      3'b000:  loadValue = {{24{b0[7]}}, b0};
      3'b001:  loadValue = {{16{b1[7]}}, b1, b0};
      3'b010:  loadValue = {b3, b2, b1, b0};
      3'b100:  loadValue = {24'd0, b0};
      3'b101:  loadValue = {16'd0, b1, b0};
      default: loadValue = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accessFire && doStore) begin
      mem[idx0] <= wdata_q[7:0];
      if (!sizeByte) begin
        mem[idx1] <= wdata_q[15:8];
      end
      if (sizeWord) begin
        mem[idx2] <= wdata_q[23:16];
        mem[idx3] <= wdata_q[31:24];
      end
    end
  end

  // Completion fields only change on the access edge and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      complRob_q      <= '0;
      complRd_q       <= '0;
      complRegWrite_q <= 1'b0;
      complValue_q    <= '0;
      complExc_q      <= 1'b0;
    end else if (accessFire) begin
      complRob_q      <= robNum_q;
      complRd_q       <= rd_q;
      complRegWrite_q <= doLoad;
      complValue_q    <= doLoad ? loadValue : 32'd0;
      complExc_q      <= excFlag;
    end
  end

  assign complete_rob_num   = complRob_q;
  assign complete_rd        = complRd_q;
  assign complete_reg_write = complRegWrite_q;
  assign complete_value     = complValue_q;
  assign complete_exception = complExc_q;

endmodule

// File: tb/tb_mem_fu.sv
// Scoreboard bench for mem_fu: stimulus pushes expected completions, a negedge
// monitor pops and compares whenever complete_valid is seen.
module tb_mem_fu;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_rob_num = '0;
  logic [5:0]  issue_rd = '0;
  logic [31:0] issue_rs1_val = '0;
  logic [31:0] issue_rs2_val = '0;
  logic [31:0] issue_imm = '0;
  logic        issue_mem_read = 1'b0;
  logic        issue_mem_write = 1'b0;
  logic [2:0]  issue_funct3 = '0;
  logic        fu_ready;
  logic        complete_valid;
  logic [3:0]  complete_rob_num;
  logic [5:0]  complete_rd;
  logic        complete_reg_write;
  logic [31:0] complete_value;
  logic        complete_exception;

  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  rd;
    logic        rw;
    logic [31:0] val;
    logic        exc;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  mem_fu #(.MEM_BYTES(1024), .MEM_LATENCY(Lat), .ROB_W(4), .PREG_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .issue_valid(issue_valid),
    .issue_rob_num(issue_rob_num),
    .issue_rd(issue_rd),
    .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val),
    .issue_imm(issue_imm),
    .issue_mem_read(issue_mem_read),
    .issue_mem_write(issue_mem_write),
    .issue_funct3(issue_funct3),
    .fu_ready(fu_ready),
    .complete_valid(complete_valid),
    .complete_rob_num(complete_rob_num),
    .complete_rd(complete_rd),
    .complete_reg_write(complete_reg_write),
    .complete_value(complete_value),
    .complete_exception(complete_exception)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_completion got rob=%0d rd=%0d value=%h", complete_rob_num,
               complete_rd, complete_value);
    end else begin
      e = expQ.pop_front();
      if (complete_rob_num !== e.rob || complete_rd !== e.rd || complete_reg_write !== e.rw ||
          complete_value !== e.val || complete_exception !== e.exc) begin
        errors++;
        $display("[TB] FAIL completion got rob=%0d rd=%0d rw=%0b val=%h exc=%0b expected rob=%0d rd=%0d rw=%0b val=%h exc=%0b",
                 complete_rob_num, complete_rd, complete_reg_write, complete_value, complete_exception,
                 e.rob, e.rd, e.rw, e.val, e.exc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (complete_valid === 1'b1) begin
      checkOutput();
    end
  end

  // Drives one op for a single cycle from an idle state; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                               input logic [3:0] rob, input logic [5:0] rd, input logic push,
                               input logic expRw, input logic [31:0] expVal, input logic expExc);
    exp_t e;
    @(negedge clk);
    issue_valid     = 1'b1;
    issue_mem_read  = r;
    issue_mem_write = w;
    issue_funct3    = f3;
    issue_rs1_val   = rs1;
    issue_imm       = imm;
    issue_rs2_val   = rs2;
    issue_rob_num   = rob;
    issue_rd        = rd;
    if (push) begin
      e.rob = rob;
      e.rd  = rd;
      e.rw  = expRw;
      e.val = expVal;
      e.exc = expExc;
      expQ.push_back(e);
    end
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 1;
    while (complete_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkValue("completion_latency", 32'(n), 32'(Lat + 1));
    @(negedge clk);
    checkValue("ready_after_resp", {31'd0, fu_ready}, 32'd1);
  endtask

  task automatic runOp(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                       input logic [3:0] rob, input logic [5:0] rd,
                       input logic expRw, input logic [31:0] expVal, input logic expExc);
    applyStimulus(r, w, f3, rs1, imm, rs2, rob, rd, 1'b1, expRw, expVal, expExc);
    waitDone();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkValue("reset_fu_ready", {31'd0, fu_ready}, 32'd1);
    checkValue("reset_valid", {31'd0, complete_valid}, 32'd0);
    checkValue("reset_rob", {28'd0, complete_rob_num}, 32'd0);
    checkValue("reset_rd", {26'd0, complete_rd}, 32'd0);
    checkValue("reset_reg_write", {31'd0, complete_reg_write}, 32'd0);
    checkValue("reset_value", complete_value, 32'd0);
    checkValue("reset_exception", {31'd0, complete_exception}, 32'd0);

    // store word then load it back, followed by sub-word loads
    runOp(1'b0, 1'b1, 3'b010, 32'h100, 32'd4, 32'hDEADBEEF, 4'd3, 6'd0, 1'b0, 32'd0, 1'b0);
    runOp(1'b1, 1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 4'd5, 6'd12, 1'b1, 32'hDEADBEEF, 1'b0);
    runOp(1'b1, 1'b0, 3'b000, 32'h100, 32'd4, 32'd0, 4'd6, 6'd1, 1'b1, 32'hFFFFFFEF, 1'b0);
    runOp(1'b1, 1'b0, 3'b100, 32'h100, 32'd7, 32'd0, 4'd7, 6'd2, 1'b1, 32'h000000DE, 1'b0);
    runOp(1'b1, 1'b0, 3'b001, 32'h100, 32'd6, 32'd0, 4'd8, 6'd3, 1'b1, 32'hFFFFDEAD, 1'b0);
    runOp(1'b1, 1'b0, 3'b101, 32'h100, 32'd4, 32'd0, 4'd9, 6'd4, 1'b1, 32'h0000BEEF, 1'b0);

    // address arithmetic: negative offset, 32-bit wrap, upper bits ignored
    runOp(1'b1, 1'b0, 3'b010, 32'h108, 32'hFFFFFFFC, 32'd0, 4'd10, 6'd5, 1'b1, 32'hDEADBEEF, 1'b0);
    runOp(1'b1, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h108, 32'd0, 4'd11, 6'd6, 1'b1, 32'hDEADBEEF, 1'b0);
    runOp(1'b1, 1'b0, 3'b010, 32'h504, 32'd0, 32'd0, 4'd12, 6'd7, 1'b1, 32'hDEADBEEF, 1'b0);

    // misaligned accesses
    runOp(1'b0, 1'b1, 3'b010, 32'h100, 32'd0, 32'h01020304, 4'd1, 6'd0, 1'b0, 32'd0, 1'b0);
    runOp(1'b1, 1'b0, 3'b010, 32'h100, 32'd2, 32'd0, 4'd2, 6'd8, 1'b0, 32'd0, 1'b1);
    runOp(1'b0, 1'b1, 3'b001, 32'h100, 32'd1, 32'h5555, 4'd3, 6'd0, 1'b0, 32'd0, 1'b1);
    runOp(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 4'd4, 6'd9, 1'b1, 32'h01020304, 1'b0);

    // byte and halfword stores
    runOp(1'b0, 1'b1, 3'b000, 32'h100, 32'd5, 32'hAABBCC77, 4'd5, 6'd0, 1'b0, 32'd0, 1'b0);
    runOp(1'b0, 1'b1, 3'b001, 32'h100, 32'd6, 32'hAABB1234, 4'd6, 6'd0, 1'b0, 32'd0, 1'b0);
    runOp(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'd0, 4'd7, 6'd10, 1'b1, 32'h123477EF, 1'b0);

    // illegal encodings and NOP
    runOp(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 4'd8, 6'd11, 1'b0, 32'd0, 1'b1);
    runOp(1'b1, 1'b0, 3'b110, 32'h100, 32'd0, 32'd0, 4'd9, 6'd12, 1'b0, 32'd0, 1'b1);
    runOp(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 4'd10, 6'd0, 1'b0, 32'd0, 1'b1);
    runOp(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 32'd0, 4'd11, 6'd13, 1'b0, 32'd0, 1'b1);
    runOp(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 4'd12, 6'd14, 1'b0, 32'd0, 1'b0);
    runOp(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 4'd13, 6'd15, 1'b1, 32'h01020304, 1'b0);

    // flush in ACCESS: store dropped, no completion
    runOp(1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'hAAAA5555, 4'd1, 6'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h11223344, 4'd2, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkValue("flush_access_ready", {31'd0, fu_ready}, 32'd1);
    repeat (4) @(negedge clk);
    runOp(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'd0, 4'd3, 6'd16, 1'b1, 32'hAAAA5555, 1'b0);

    // flush in RESP suppresses the completion pulse
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'd0, 4'd4, 6'd17, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    #1 checkValue("flush_resp_valid", {31'd0, complete_valid}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkValue("flush_resp_ready", {31'd0, fu_ready}, 32'd1);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    issue_valid     = 1'b1;
    issue_mem_read  = 1'b1;
    issue_mem_write = 1'b0;
    issue_rob_num   = 4'd9;
    flush           = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    flush       = 1'b0;
    checkValue("flush_idle_ready", {31'd0, fu_ready}, 32'd1);
    repeat (4) @(negedge clk);

    // reset mid-ACCESS aborts a store
    runOp(1'b0, 1'b1, 3'b010, 32'h300, 32'd0, 32'h0BADF00D, 4'd14, 6'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h300, 32'd0, 32'h12345678, 4'd15, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    checkValue("reset_mid_ready", {31'd0, fu_ready}, 32'd1);
    checkValue("reset_mid_valid", {31'd0, complete_valid}, 32'd0);
    checkValue("reset_mid_rob", {28'd0, complete_rob_num}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    runOp(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 4'd1, 6'd18, 1'b1, 32'h0BADF00D, 1'b0);

    // busy handshake: issue_valid held high, tag changes every cycle
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkValue("busy_ready", {31'd0, fu_ready}, (k % (Lat + 2) == 0) ? 32'd1 : 32'd0);
      issue_valid     = 1'b1;
      issue_mem_read  = 1'b1;
      issue_mem_write = 1'b0;
      issue_funct3    = 3'b010;
      issue_rs1_val   = 32'h100;
      issue_imm       = 32'd0;
      issue_rob_num   = 4'(k);
      issue_rd        = 6'(k);
      if (k % (Lat + 2) == 0) begin
        e.rob = 4'(k);
        e.rd  = 6'(k);
        e.rw  = 1'b1;
        e.val = 32'h01020304;
        e.exc = 1'b0;
        expQ.push_back(e);
      end
    end
    @(negedge clk);
    issue_valid = 1'b0;
    for (int t = 0; t < 20 && expQ.size() != 0; t++) begin
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checkValue("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
